// File: rtl/sram_wrapper_sky130.sv
// Single-port 1RW SRAM wrapper modelled on a sky130 OpenRAM macro.
// Requests are registered first, then the array is accessed on the next edge.
module sram_wrapper_sky130 #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic                   we_q, we_d;
  logic [WMASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  din_q, din_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic                   mem_wr;

  // Zero contents at time zero, as the macro's behavioral model does.
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH] = '{default: '0};

  always_comb begin
    we_d    = we;
    wmask_d = wmask;
    addr_d  = addr;
    din_d   = din;
    dout_d  = dout_q;
    mem_wr  = reset_n && we_q;
    if (!we_q) begin
      dout_d = mem_q[addr_q];
    end
    if (!reset_n) begin
      we_d    = 1'b0;
      wmask_d = '0;
      addr_d  = '0;
      din_d   = '0;
      dout_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    we_q    <= we_d;
    wmask_q <= wmask_d;
    addr_q  <= addr_d;
    din_q   <= din_d;
    dout_q  <= dout_d;
  end

  // Pending writes are dropped when reset arrives at the access edge.
  always_ff @(posedge clock) begin
    for (int i = 0; i < WMASK_WIDTH; i++) begin
      if (mem_wr && wmask_q[i]) begin
        mem_q[addr_q][8*i +: 8] <= din_q[8*i +: 8];
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_sram_wrapper_sky130.sv
// Directed bench for sram_wrapper_sky130.
// Inputs change 1ns after each rising edge; dout is sampled there too.
module tb_sram_wrapper_sky130;

  logic        clock;
  logic        reset_n;
  logic        we;
  logic [3:0]  wmask;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  int n_chk;
  int n_pass;

  sram_wrapper_sky130 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (we),
    .wmask   (wmask),
    .addr    (addr),
    .din     (din),
    .dout    (dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic        w,
                     input logic [3:0]  m,
                     input logic [7:0]  a,
                     input logic [31:0] d);
    we    = w;
    wmask = m;
    addr  = a;
    din   = d;
    tick();
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    reset_n = 1'b0;
    we      = 1'b0;
    wmask   = '0;
    addr    = '0;
    din     = '0;

    tick();
    tick();
    chk("reset_dout", dout, 32'h0);
    reset_n = 1'b1;
    req(0, 4'h0, 8'd0, 32'h0);
    req(0, 4'h0, 8'd0, 32'h0);
    chk("rd0_init", dout, 32'h0);

    req(1, 4'hF, 8'd0, 32'h0D0D0D0D);
    chk("wr_hold_a", dout, 32'h0);
    req(0, 4'h0, 8'd0, 32'h0);
    chk("wr_hold_b", dout, 32'h0);
    req(0, 4'h0, 8'd0, 32'h0);
    chk("rd0_full", dout, 32'h0D0D0D0D);

    req(1, 4'hF, 8'd5, 32'hFFFFFFFF);
    req(1, 4'h5, 8'd5, 32'h12345678);
    req(0, 4'h0, 8'd5, 32'h0);
    req(0, 4'h0, 8'd5, 32'h0);
    chk("bytemask", dout, 32'hFF34FF78);

    req(1, 4'hF, 8'd255, 32'hA5A5A5A5);
    req(0, 4'h0, 8'd255, 32'h0);
    req(0, 4'h0, 8'd255, 32'h0);
    chk("raw_255", dout, 32'hA5A5A5A5);

    req(1, 4'hF, 8'd1, 32'h11110001);
    req(1, 4'hF, 8'd2, 32'h22220002);
    req(0, 4'h0, 8'd2, 32'h0);
    req(0, 4'h0, 8'd1, 32'h0);
    chk("rd_addr2", dout, 32'h22220002);
    req(0, 4'h0, 8'd1, 32'h0);
    chk("rd_addr1", dout, 32'h11110001);

    req(1, 4'hF, 8'd7, 32'hDEADBEEF);
    reset_n = 1'b0;
    we      = 1'b0;
    tick();
    chk("rst_mid_a", dout, 32'h0);
    tick();
    chk("rst_mid_b", dout, 32'h0);
    reset_n = 1'b1;
    req(0, 4'h0, 8'd7, 32'h0);
    chk("post_rst_rd0", dout, 32'h0D0D0D0D);
    req(0, 4'h0, 8'd7, 32'h0);
    chk("rst_drop_wr", dout, 32'h0);

    req(1, 4'hF, 8'd3, 32'hCAFEF00D);
    req(1, 4'h0, 8'd3, 32'h11111111);
    req(0, 4'h0, 8'd3, 32'h0);
    chk("zmask_hold", dout, 32'h0);
    req(0, 4'h0, 8'd3, 32'h0);
    chk("zmask_rd", dout, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
